// File: rtl/debounce_event_arbiter_if.sv
// Event port between the debounce arbiter (master) and its downstream consumer (slave).
// DBNC_TIMESTAMP_EN adds evt_time to the bundle.
interface debounce_event_arbiter_if #(
    parameter int CH_W = 2,
    parameter int TS_W = 16
);
    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_chan;
    logic            evt_level;
    logic            evt_overrun;
`ifdef DBNC_TIMESTAMP_EN
    logic [TS_W-1:0] evt_time;

    modport master (output evt_valid, evt_chan, evt_level, evt_overrun, evt_time,
                    input  evt_ready);
    modport slave  (input  evt_valid, evt_chan, evt_level, evt_overrun, evt_time,
                    output evt_ready);
`else
    modport master (output evt_valid, evt_chan, evt_level, evt_overrun,
                    input  evt_ready);
    modport slave  (input  evt_valid, evt_chan, evt_level, evt_overrun,
                    output evt_ready);
`endif

    if (CH_W < 1 || TS_W < 1) begin : g_bad_width
        $error("debounce_event_arbiter_if: CH_W and TS_W must be >= 1");
    end
endinterface

// File: rtl/debounce_event_arbiter.sv
// Shared debounce tick, per-channel change detection with one-deep event queue, and
// round-robin arbitration onto a valid/ready event port. Optional DBNC_TIMESTAMP_EN adds evt_time.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | nothing presented; grants the next pending channel if any
// PRESENT | evt_* presented and held until the consumer asserts evt_ready
module debounce_event_arbiter #(
    parameter int N_CH     = 4,
    parameter int TICK_DIV = 500000,
    parameter int CH_W     = 2,
    parameter int TS_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          db_in,
    output logic                     tick_out,
    output logic [N_CH-1:0]          pending,
    debounce_event_arbiter_if.master evt
);

    typedef enum logic {IDLE, PRESENT} state_t;

    localparam int              PS_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    if (CH_W != $clog2(N_CH) || N_CH < 2 || TICK_DIV < 2 || TS_W < 1) begin : g_bad_param
        $error("debounce_event_arbiter: illegal parameter combination");
    end

    state_t          state, state_nxt;
    logic [PS_W-1:0] presc, presc_nxt;
    logic [N_CH-1:0] db_q, db_edge;
    logic [N_CH-1:0] lvl, ovr;
    logic [CH_W-1:0] rr;
    logic [CH_W-1:0] cand;
    logic [CH_W-1:0] gnt_idx;
    logic            gnt_found, gnt_take;
    logic [N_CH-1:0] gnt_hit;

    // tick_out is registered so it is high exactly while presc sits at its last count
    always_comb begin
        presc_nxt = (presc == PS_LAST) ? '0 : presc + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            tick_out <= 1'b0;
        end else begin
            presc    <= presc_nxt;
            tick_out <= (presc_nxt == PS_LAST);
        end
    end

    assign db_edge = db_in ^ db_q;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = CH_W'((int'(rr) + k) % N_CH);
            if (!gnt_found && pending[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign gnt_take = (state == IDLE) && gnt_found;

    always_comb begin
        gnt_hit = '0;
        if (gnt_take) gnt_hit[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        evt.evt_valid = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found) state_nxt = PRESENT;
            end
            PRESENT: begin
                evt.evt_valid = 1'b1;
                if (evt.evt_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A new edge beats a simultaneous grant; overrun only when the pending event is not leaving
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_q    <= '0;
            pending <= '0;
            lvl     <= '0;
            ovr     <= '0;
        end else begin
            db_q <= db_in;
            for (int i = 0; i < N_CH; i++) begin
                if (db_edge[i]) begin
                    pending[i] <= 1'b1;
                    lvl[i]     <= db_in[i];
                    if (pending[i] && !gnt_hit[i]) ovr[i] <= 1'b1;
                    else if (gnt_hit[i])           ovr[i] <= 1'b0;
                end else if (gnt_hit[i]) begin
                    pending[i] <= 1'b0;
                    ovr[i]     <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr              <= CH_W'(N_CH - 1);
            evt.evt_chan    <= '0;
            evt.evt_level   <= 1'b0;
            evt.evt_overrun <= 1'b0;
        end else if (gnt_take) begin
            rr              <= gnt_idx;
            evt.evt_chan    <= gnt_idx;
            evt.evt_level   <= lvl[gnt_idx];
            evt.evt_overrun <= ovr[gnt_idx];
        end
    end

`ifdef DBNC_TIMESTAMP_EN
    logic [TS_W-1:0] tick_cnt;
    logic [TS_W-1:0] ts_ch [N_CH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt     <= '0;
            evt.evt_time <= '0;
            for (int i = 0; i < N_CH; i++) ts_ch[i] <= '0;
        end else begin
            if (tick_out) tick_cnt <= tick_cnt + 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                if (db_edge[i]) ts_ch[i] <= tick_cnt;
            end
            if (gnt_take) evt.evt_time <= ts_ch[gnt_idx];
        end
    end
`endif

endmodule

// File: tb/tb_debounce_event_arbiter.sv
// Directed bench for debounce_event_arbiter: cycle table for tick/latency/fairness/reset,
// plus hand sequences for overrun and same-cycle grant/edge.
module tb_debounce_event_arbiter;
    localparam int N_CH     = 4;
    localparam int TICK_DIV = 4;
    localparam int CH_W     = 2;
    localparam int TS_W     = 16;
    localparam int NVEC     = 28;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] db_in;
    logic            tick_out;
    logic [N_CH-1:0] pending;

    debounce_event_arbiter_if #(.CH_W(CH_W), .TS_W(TS_W)) evt_if ();

    debounce_event_arbiter #(
        .N_CH(N_CH), .TICK_DIV(TICK_DIV), .CH_W(CH_W), .TS_W(TS_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .db_in    (db_in),
        .tick_out (tick_out),
        .pending  (pending),
        .evt      (evt_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [3:0] db;
        logic       rdy;
        logic       tick;
        logic       valid;
        logic [1:0] chan;
        logic       level;
        logic       ovr;
        logic [3:0] pend;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic rst, input logic [3:0] db, input logic rdy,
                                input logic tick, input logic valid, input logic [1:0] chan,
                                input logic level, input logic ovr, input logic [3:0] pend);
        vec_t v;
        v.rst = rst; v.db = db; v.rdy = rdy; v.tick = tick; v.valid = valid;
        v.chan = chan; v.level = level; v.ovr = ovr; v.pend = pend;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_evt(input string nm, input logic valid, input logic [1:0] chan,
                           input logic level, input logic ovr, input logic [3:0] pend);
        chk({nm, "_valid"}, 32'(evt_if.evt_valid), 32'(valid));
        chk({nm, "_pend"}, 32'(pending), 32'(pend));
        if (valid) begin
            chk({nm, "_chan"}, 32'(evt_if.evt_chan), 32'(chan));
            chk({nm, "_level"}, 32'(evt_if.evt_level), 32'(level));
            chk({nm, "_ovr"}, 32'(evt_if.evt_overrun), 32'(ovr));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           rst db       rdy tick val ch  lvl ovr pend
        tbl[0]  = mk(0, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000);
        tbl[1]  = mk(0, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000);
        tbl[2]  = mk(0, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000);
        tbl[3]  = mk(0, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000);
        tbl[4]  = mk(0, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000);
        tbl[5]  = mk(0, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000);
        tbl[6]  = mk(0, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000);
        tbl[7]  = mk(0, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000);
        tbl[8]  = mk(0, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000);
        tbl[9]  = mk(0, 4'b0001, 1, 0, 0, 0, 0, 0, 4'b0000);
        tbl[10] = mk(0, 4'b0001, 1, 0, 0, 0, 0, 0, 4'b0001);
        tbl[11] = mk(0, 4'b0001, 1, 1, 1, 0, 1, 0, 4'b0000);
        tbl[12] = mk(0, 4'b0001, 1, 0, 0, 0, 0, 0, 4'b0000);
        tbl[13] = mk(0, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000);
        tbl[14] = mk(0, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0001);
        tbl[15] = mk(0, 4'b0010, 0, 1, 1, 0, 0, 0, 4'b0000);
        tbl[16] = mk(0, 4'b0010, 0, 0, 1, 0, 0, 0, 4'b0010);
        tbl[17] = mk(1, 4'b1111, 0, 0, 0, 0, 0, 0, 4'b0000);
        tbl[18] = mk(0, 4'b1111, 1, 0, 0, 0, 0, 0, 4'b0000);
        tbl[19] = mk(0, 4'b1111, 1, 0, 0, 0, 0, 0, 4'b1111);
        tbl[20] = mk(0, 4'b1111, 1, 0, 1, 0, 1, 0, 4'b1110);
        tbl[21] = mk(0, 4'b1111, 1, 1, 0, 0, 0, 0, 4'b1110);
        tbl[22] = mk(0, 4'b1111, 1, 0, 1, 1, 1, 0, 4'b1100);
        tbl[23] = mk(0, 4'b1111, 1, 0, 0, 0, 0, 0, 4'b1100);
        tbl[24] = mk(0, 4'b1111, 1, 0, 1, 2, 1, 0, 4'b1000);
        tbl[25] = mk(0, 4'b1111, 1, 1, 0, 0, 0, 0, 4'b1000);
        tbl[26] = mk(0, 4'b1111, 1, 0, 1, 3, 1, 0, 4'b0000);
        tbl[27] = mk(0, 4'b1111, 1, 0, 0, 0, 0, 0, 4'b0000);

        reset            = 1'b1;
        db_in            = '0;
        evt_if.evt_ready = 1'b0;
        repeat (3) next_cycle();
        chk("rst_tick", 32'(tick_out), 32'd0);
        chk("rst_chan", 32'(evt_if.evt_chan), 32'd0);
        chk("rst_level", 32'(evt_if.evt_level), 32'd0);
        chk("rst_ovr", 32'(evt_if.evt_overrun), 32'd0);
        chk_evt("rst", 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000);
        next_cycle();

        for (int i = 0; i < NVEC; i++) begin
            if (i > 0) next_cycle();
            reset            = tbl[i].rst;
            db_in            = tbl[i].db;
            evt_if.evt_ready = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_tick", i + 1), 32'(tick_out), 32'(tbl[i].tick));
            chk_evt($sformatf("tbl%0d", i + 1), tbl[i].valid, tbl[i].chan, tbl[i].level,
                    tbl[i].ovr, tbl[i].pend);
            if (tbl[i].rst) begin
                chk($sformatf("tbl%0d_rchan", i + 1), 32'(evt_if.evt_chan), 32'd0);
                chk($sformatf("tbl%0d_rovr", i + 1), 32'(evt_if.evt_overrun), 32'd0);
            end
        end

        // Overrun: ch0 event stalls the port while ch2 changes three times
        next_cycle();
        reset = 1'b1; db_in = 4'b0000; evt_if.evt_ready = 1'b0;
        next_cycle();
        reset = 1'b0; db_in = 4'b0001;
        next_cycle();
        chk_evt("ovr_a", 1'b0, 2'd0, 1'b0, 1'b0, 4'b0001);
        next_cycle();
        chk_evt("ovr_b", 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000);
        db_in = 4'b0101;
        next_cycle();
        chk_evt("ovr_c", 1'b1, 2'd0, 1'b1, 1'b0, 4'b0100);
        db_in = 4'b0001;
        next_cycle();
        db_in = 4'b0101;
        next_cycle();
        chk_evt("ovr_d", 1'b1, 2'd0, 1'b1, 1'b0, 4'b0100);
`ifdef DBNC_TIMESTAMP_EN
        chk("ovr_time0", 32'(evt_if.evt_time), 32'd0);
`endif
        evt_if.evt_ready = 1'b1;
        next_cycle();
        evt_if.evt_ready = 1'b0;
        chk_evt("ovr_e", 1'b0, 2'd0, 1'b0, 1'b0, 4'b0100);
        next_cycle();
        chk_evt("ovr_f", 1'b1, 2'd2, 1'b1, 1'b1, 4'b0000);
`ifdef DBNC_TIMESTAMP_EN
        chk("ovr_time2", 32'(evt_if.evt_time), 32'd1);
`endif
        next_cycle();
        chk_evt("ovr_hold", 1'b1, 2'd2, 1'b1, 1'b1, 4'b0000);
        evt_if.evt_ready = 1'b1;
        next_cycle();
        chk_evt("ovr_done", 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000);

        // ch1 edges again in the very cycle its pending event is granted
        db_in = 4'b0111;
        next_cycle();
        chk_evt("sim_a", 1'b0, 2'd0, 1'b0, 1'b0, 4'b0010);
        db_in = 4'b0101;
        next_cycle();
        chk_evt("sim_b", 1'b1, 2'd1, 1'b1, 1'b0, 4'b0010);
        next_cycle();
        chk_evt("sim_c", 1'b0, 2'd0, 1'b0, 1'b0, 4'b0010);
        next_cycle();
        chk_evt("sim_d", 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000);
        next_cycle();
        chk_evt("sim_e", 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
